// File: rtl/cpu_axi_mem_bridge.sv
// Bridge between the RV32IM MEM stage and the single-beat start/busy command
// interface of the AXI4-Lite peripheral subsystem. Formats stores into byte
// strobes with lane-replicated data, formats loads with sign/zero extension,
// and stalls the pipeline until the peripheral transaction has completed.
module cpu_axi_mem_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [2:0]            mem_funct3,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_done,
    output logic                  mem_err,
    output logic                  mem_stall,
    output logic                  write_start,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic [3:0]            write_strobe,
    input  logic                  write_busy,
    output logic                  read_start,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] read_data,
    input  logic                  read_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            addr_lo_q, addr_lo_d;
    logic [2:0]            funct3_q, funct3_d;
    logic                  is_write_q, is_write_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  wstart_q, wstart_d;
    logic                  rstart_q, rstart_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  request;
    logic                  busy_sel;
    logic [ADDR_WIDTH-1:0] aligned_addr;

    // Misaligned halfword/word accesses, reserved funct3 codes and unsigned
    // store widths are rejected before anything reaches the peripheral.
    function automatic logic access_legal(input logic       is_wr,
                                          input logic [2:0] f3,
                                          input logic [1:0] lo);
        logic ok;
        case (f3)
            3'b000:  ok = 1'b1;
            3'b001:  ok = ~lo[0];
            3'b010:  ok = (lo == 2'b00);
            3'b100:  ok = ~is_wr;
            3'b101:  ok = ~is_wr & ~lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] store_strobe(input logic [2:0] f3,
                                                input logic [1:0] lo);
        logic [3:0] s;
        case (f3)
            3'b000:  s = 4'b0001 << lo;
            3'b001:  s = lo[1] ? 4'b1100 : 4'b0011;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    // Narrow stores are replicated across every lane so the strobe alone
    // selects the destination bytes.
    function automatic logic [DATA_WIDTH-1:0] store_data(input logic [2:0]            f3,
                                                         input logic [DATA_WIDTH-1:0] wd);
        logic [DATA_WIDTH-1:0] d;
        case (f3)
            3'b000:  d = {4{wd[7:0]}};
            3'b001:  d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] load_format(input logic [2:0]            f3,
                                                          input logic [1:0]            lo,
                                                          input logic [DATA_WIDTH-1:0] word);
        logic [7:0]            b;
        logic [15:0]           h;
        logic [DATA_WIDTH-1:0] r;
        case (lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'h000000, b};
            3'b101:  r = {16'h0000, h};
            default: r = word;
        endcase
        return r;
    endfunction

    assign request      = mem_read | mem_write;
    assign busy_sel     = is_write_q ? write_busy : read_busy;
    assign aligned_addr = {mem_addr[ADDR_WIDTH-1:2], 2'b00};

    // Next-state and command formatting; pulses default low every cycle.
    always_comb begin
        state_d    = state_q;
        addr_lo_d  = addr_lo_q;
        funct3_d   = funct3_q;
        is_write_d = is_write_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        wstart_d   = 1'b0;
        rstart_d   = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        raddr_d    = raddr_q;
        rdata_d    = rdata_q;
        case (state_q)
            IDLE: begin
                if (request) begin
                    // A simultaneous read and write is treated as a write.
                    addr_lo_d  = mem_addr[1:0];
                    funct3_d   = mem_funct3;
                    is_write_d = mem_write;
                    if (access_legal(mem_write, mem_funct3, mem_addr[1:0])) begin
                        if (mem_write) begin
                            wstart_d = 1'b1;
                            waddr_d  = aligned_addr;
                            wdata_d  = store_data(mem_funct3, mem_wdata);
                            wstrb_d  = store_strobe(mem_funct3, mem_addr[1:0]);
                        end else begin
                            rstart_d = 1'b1;
                            raddr_d  = aligned_addr;
                        end
                        state_d = ARM;
                    end else begin
                        rdata_d = '0;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            ARM: begin
                // The peripheral raises busy one cycle after start, so busy
                // is not meaningful here.
                state_d = WAIT;
            end
            WAIT: begin
                if (!busy_sel) begin
                    if (!is_write_q) begin
                        rdata_d = load_format(funct3_q, addr_lo_q, read_data);
                    end
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and request context registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_lo_q  <= 2'b00;
            funct3_q   <= 3'b000;
            is_write_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_lo_q  <= addr_lo_d;
            funct3_q   <= funct3_d;
            is_write_q <= is_write_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Peripheral command and load result registers; cleared on reset so an
    // aborted transaction leaves nothing asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            wstart_q <= 1'b0;
            rstart_q <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            wstrb_q  <= 4'b0000;
            raddr_q  <= '0;
            rdata_q  <= '0;
        end else begin
            wstart_q <= wstart_d;
            rstart_q <= rstart_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            raddr_q  <= raddr_d;
            rdata_q  <= rdata_d;
        end
    end

    // Stall drops in DONE so the core advances on the same edge the bridge
    // returns to IDLE.
    assign mem_stall    = ((state_q == IDLE) & request) | (state_q == ARM) | (state_q == WAIT);
    assign mem_done     = done_q;
    assign mem_err      = err_q;
    assign mem_rdata    = rdata_q;
    assign write_start  = wstart_q;
    assign write_addr   = waddr_q;
    assign write_data   = wdata_q;
    assign write_strobe = wstrb_q;
    assign read_start   = rstart_q;
    assign read_addr    = raddr_q;

endmodule

// File: tb/tb_cpu_axi_mem_bridge.sv
// Self-checking bench for cpu_axi_mem_bridge: a directed vector table, a
// randomized phase against a byte-level memory model, and reset corner cases.
module tb_cpu_axi_mem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rdata;
    logic        mem_done, mem_err, mem_stall;
    logic        write_start;
    logic [31:0] write_addr, write_data;
    logic [3:0]  write_strobe;
    logic        write_busy = 1'b0;
    logic        read_start;
    logic [31:0] read_addr;
    logic [31:0] read_data = 32'h0;
    logic        read_busy = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_axi_mem_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_err(mem_err), .mem_stall(mem_stall),
        .write_start(write_start), .write_addr(write_addr), .write_data(write_data),
        .write_strobe(write_strobe), .write_busy(write_busy),
        .read_start(read_start), .read_addr(read_addr), .read_data(read_data),
        .read_busy(read_busy)
    );

    // ---------------- peripheral model: word memory with programmable busy
    logic [31:0] pmem [0:255] = '{default: 32'h0};
    int          per_lat = 1;
    int          cnt_q = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            write_busy <= 1'b0;
            read_busy  <= 1'b0;
            cnt_q      <= 0;
        end else if (write_start) begin
            if (per_lat == 0) pmem[write_addr[9:2]] <= merge(pmem[write_addr[9:2]], write_data, write_strobe);
            else begin write_busy <= 1'b1; cnt_q <= per_lat; end
        end else if (read_start) begin
            if (per_lat == 0) read_data <= pmem[read_addr[9:2]];
            else begin read_busy <= 1'b1; cnt_q <= per_lat; end
        end else if (cnt_q != 0) begin
            cnt_q <= cnt_q - 1;
            if (cnt_q == 1) begin
                if (write_busy) begin
                    pmem[write_addr[9:2]] <= merge(pmem[write_addr[9:2]], write_data, write_strobe);
                    write_busy <= 1'b0;
                end
                if (read_busy) begin
                    read_data <= pmem[read_addr[9:2]];
                    read_busy <= 1'b0;
                end
            end
        end
    end

    // ---------------- reference model: byte-addressed memory and RV32 rules
    logic [7:0]  ref_mem [0:1023];
    logic [31:0] hold;

    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic model_legal(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b0;
        if (wr && f3[2]) return 1'b0;
        return (int'(a[1:0]) % size_of(f3)) == 0;
    endfunction

    function automatic logic [3:0] model_strb(input logic [31:0] a, input logic [2:0] f3);
        logic [3:0] s;
        int off, n;
        off = int'(a[1:0]);
        n = size_of(f3);
        for (int i = 0; i < 4; i++) s[i] = (i >= off) && (i < off + n);
        return s;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [2:0] f3);
        logic [31:0] d;
        int n;
        n = size_of(f3);
        for (int i = 0; i < 4; i++) d[8*i +: 8] = wd[8*(i % n) +: 8];
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] v;
        int n;
        n = size_of(f3);
        v = 32'h0;
        for (int j = 0; j < n; j++) v = v | (32'(ref_mem[int'(a[9:0]) + j]) << (8*j));
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
        for (int j = 0; j < size_of(f3); j++) ref_mem[int'(a[9:0]) + j] = wd[8*j +: 8];
    endtask

    // ---------------- checking helpers
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive one request in the cycle after the previous completion and watch
    // it to completion (bounded), capturing the commands issued.
    task automatic run_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [2:0] f3, input int lat,
                           output int done_k, output logic err, output logic [31:0] rdata,
                           output int nws, output int nrs,
                           output logic [31:0] cap_waddr, output logic [31:0] cap_wdata,
                           output logic [3:0] cap_strb, output logic [31:0] cap_raddr,
                           output logic ctl_ok);
        @(negedge clk);
        per_lat = lat;
        mem_read = rd; mem_write = wr; mem_addr = a; mem_wdata = wd; mem_funct3 = f3;
        done_k = -1; err = 1'b0; rdata = 32'h0; nws = 0; nrs = 0;
        cap_waddr = 32'h0; cap_wdata = 32'h0; cap_strb = 4'h0; cap_raddr = 32'h0; ctl_ok = 1'b1;
        #1;
        if (mem_stall !== 1'b1 || mem_done !== 1'b0) ctl_ok = 1'b0;
        for (int k = 1; k <= 40 && done_k < 0; k++) begin
            @(negedge clk);
            if (write_start === 1'b1) begin
                nws++; cap_waddr = write_addr; cap_wdata = write_data; cap_strb = write_strobe;
            end else if (nws > 0 && (write_addr !== cap_waddr || write_data !== cap_wdata || write_strobe !== cap_strb)) begin
                ctl_ok = 1'b0;
            end
            if (read_start === 1'b1) begin
                nrs++; cap_raddr = read_addr;
            end else if (nrs > 0 && read_addr !== cap_raddr) begin
                ctl_ok = 1'b0;
            end
            if (mem_done === 1'b1) begin
                done_k = k; err = mem_err; rdata = mem_rdata;
                if (mem_stall !== 1'b0) ctl_ok = 1'b0;
                mem_read = 1'b0; mem_write = 1'b0;
            end else if (mem_err !== 1'b0 || mem_stall !== 1'b1) begin
                ctl_ok = 1'b0;
            end
        end
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic apply(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] f3, input int lat,
                         input logic exp_err, input logic [31:0] exp_rdata, input logic [31:0] exp_caddr,
                         input logic [31:0] exp_cwdata, input logic [3:0] exp_strb);
        int done_k, nws, nrs;
        logic err, ctl_ok;
        logic [31:0] rdata, cwa, cwd, cra;
        logic [3:0] cs;
        run_req(rd, wr, a, wd, f3, lat, done_k, err, rdata, nws, nrs, cwa, cwd, cs, cra, ctl_ok);
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        chk({tag, "_latency"}, done_k, exp_err ? 1 : 3 + lat);
        chk({tag, "_rdata"}, rdata, exp_rdata);
        chk({tag, "_wstarts"}, nws, (!exp_err && wr) ? 1 : 0);
        chk({tag, "_rstarts"}, nrs, (!exp_err && !wr) ? 1 : 0);
        chk({tag, "_stall_stable"}, 32'(ctl_ok), 32'd1);
        if (!exp_err && wr) begin
            chk({tag, "_waddr"}, cwa, exp_caddr);
            chk({tag, "_wdata"}, cwd, exp_cwdata);
            chk({tag, "_wstrb"}, 32'(cs), 32'(exp_strb));
        end
        if (!exp_err && !wr) chk({tag, "_raddr"}, cra, exp_caddr);
    endtask

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [3:0]  lat;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] caddr;
        logic [31:0] cwdata;
        logic [3:0]  strb;
    } vec_t;

    vec_t vecs [17];

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {25'h0, mem_done, mem_err, mem_stall, write_start, read_start, 2'b00}, 32'h0);
        chk({tag, "_strobe"}, 32'(write_strobe), 32'h0);
        chk({tag, "_rdata"}, mem_rdata, 32'h0);
        chk({tag, "_waddr"}, write_addr, 32'h0);
        chk({tag, "_wdata"}, write_data, 32'h0);
        chk({tag, "_raddr"}, read_addr, 32'h0);
    endtask

    initial begin
        logic rd, wr, lg;
        logic [31:0] a, wd, er;
        logic [2:0] f3;
        int lat, sel, nodone;

        //          rd    wr    addr      wdata         f3      lat  err   rdata         cmd addr  cmd wdata     strb
        vecs[0]  = '{1'b0, 1'b1, 32'h004, 32'hAABBCCDD, 3'b010, 4'd1, 1'b0, 32'h00000000, 32'h004, 32'hAABBCCDD, 4'b1111};
        vecs[1]  = '{1'b0, 1'b1, 32'h106, 32'h000000EE, 3'b000, 4'd2, 1'b0, 32'h00000000, 32'h104, 32'hEEEEEEEE, 4'b0100};
        vecs[2]  = '{1'b1, 1'b0, 32'h104, 32'h00000000, 3'b010, 4'd0, 1'b0, 32'h00EE0000, 32'h104, 32'h0, 4'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'h008, 32'h80FF7F01, 3'b010, 4'd3, 1'b0, 32'h00EE0000, 32'h008, 32'h80FF7F01, 4'b1111};
        vecs[4]  = '{1'b1, 1'b0, 32'h008, 32'h00000000, 3'b000, 4'd1, 1'b0, 32'h00000001, 32'h008, 32'h0, 4'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h00B, 32'h00000000, 3'b000, 4'd2, 1'b0, 32'hFFFFFF80, 32'h008, 32'h0, 4'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'h00B, 32'h00000000, 3'b100, 4'd1, 1'b0, 32'h00000080, 32'h008, 32'h0, 4'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h00A, 32'h00000000, 3'b001, 4'd0, 1'b0, 32'hFFFF80FF, 32'h008, 32'h0, 4'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'h00A, 32'h00000000, 3'b101, 4'd3, 1'b0, 32'h000080FF, 32'h008, 32'h0, 4'b0};
        vecs[9]  = '{1'b1, 1'b0, 32'h006, 32'h00000000, 3'b010, 4'd1, 1'b1, 32'h00000000, 32'h0, 32'h0, 4'b0};
        vecs[10] = '{1'b1, 1'b0, 32'h004, 32'h00000000, 3'b010, 4'd1, 1'b0, 32'hAABBCCDD, 32'h004, 32'h0, 4'b0};
        vecs[11] = '{1'b0, 1'b1, 32'h005, 32'h12345678, 3'b001, 4'd1, 1'b1, 32'h00000000, 32'h0, 32'h0, 4'b0};
        vecs[12] = '{1'b1, 1'b1, 32'h108, 32'hABABABAB, 3'b010, 4'd2, 1'b0, 32'h00000000, 32'h108, 32'hABABABAB, 4'b1111};
        vecs[13] = '{1'b1, 1'b0, 32'h108, 32'h00000000, 3'b010, 4'd1, 1'b0, 32'hABABABAB, 32'h108, 32'h0, 4'b0};
        vecs[14] = '{1'b1, 1'b0, 32'h000, 32'h00000000, 3'b011, 4'd1, 1'b1, 32'h00000000, 32'h0, 32'h0, 4'b0};
        vecs[15] = '{1'b0, 1'b1, 32'h000, 32'h0000005A, 3'b100, 4'd1, 1'b1, 32'h00000000, 32'h0, 32'h0, 4'b0};
        vecs[16] = '{1'b1, 1'b0, 32'h007, 32'h00000000, 3'b001, 4'd1, 1'b1, 32'h00000000, 32'h0, 32'h0, 4'b0};

        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        hold = 32'h0;
        rst = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_funct3 = 3'b000;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("post_reset_idle");

        // Directed table.
        foreach (vecs[i]) begin
            apply($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].f3,
                  int'(vecs[i].lat), vecs[i].err, vecs[i].rdata, vecs[i].caddr, vecs[i].cwdata, vecs[i].strb);
            if (!vecs[i].err && vecs[i].wr) model_store(vecs[i].addr, vecs[i].wdata, vecs[i].f3);
            hold = vecs[i].rdata;
        end

        // Randomized accesses in 0x200..0x3FF, checked against the byte model.
        for (int t = 0; t < 60; t++) begin
            sel = $urandom_range(0, 3);
            rd = (sel != 1); wr = (sel == 1 || sel == 2);
            f3 = 3'($urandom_range(0, 7));
            a = 32'h200 + 32'($urandom_range(0, 511));
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            wd = $urandom;
            lat = $urandom_range(0, 3);
            lg = model_legal(wr, f3, a);
            er = !lg ? 32'h0 : (wr ? hold : model_load(a, f3));
            apply($sformatf("rnd%0d", t), rd, wr, a, wd, f3, lat, !lg, er,
                  {a[31:2], 2'b00}, model_wdata(wd, f3), model_strb(a, f3));
            if (lg && wr) model_store(a, wd, f3);
            hold = er;
        end

        // Load a nonzero value so the mid-transaction reset visibly clears it.
        apply("pre_abort_lw", 1'b1, 1'b0, 32'h108, 32'h0, 3'b010, 1, 1'b0, 32'hABABABAB, 32'h108, 32'h0, 4'b0);

        // Reset while waiting on a long read.
        @(negedge clk);
        per_lat = 6;
        mem_read = 1'b1; mem_write = 1'b0; mem_addr = 32'h004; mem_funct3 = 3'b010;
        @(negedge clk);
        chk("abort_read_start", 32'(read_start), 32'd1);
        @(negedge clk);
        chk("abort_in_wait", {30'h0, mem_stall, read_busy}, 32'h3);
        rst = 1'b1; mem_read = 1'b0;
        @(negedge clk);
        chk_all_zero("abort");
        rst = 1'b0;
        nodone = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mem_done !== 1'b0 || mem_stall !== 1'b0 || read_start !== 1'b0) nodone++;
        end
        chk("abort_quiet", nodone, 0);
        hold = 32'h0;

        apply("after_abort_lw", 1'b1, 1'b0, 32'h004, 32'h0, 3'b010, 2, 1'b0, 32'hAABBCCDD, 32'h004, 32'h0, 4'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
